// File: rtl/parallel_to_serial.sv
// parallel_to_serial: LSB-first serializer with valid/ready on both sides and a
// one-word holding buffer so consecutive words stream with no idle cycle.
module parallel_to_serial #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [width-1:0] parallel_data,
    output logic             parallel_ready,
    input  logic             serial_ready,
    output logic             serial_valid,
    output logic             serial_data,
    output logic             serial_last
);
    localparam int CW = $clog2(width);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           r_state;
    logic [width-1:0] r_shift;
    logic [width-1:0] r_buf;
    logic             r_buf_full;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_xfer;
    logic             w_last;
    assign w_last         = r_cnt == CW'(width - 1);
    assign parallel_ready = !r_buf_full;
    assign serial_valid   = r_state == SHIFT;
    assign serial_data    = r_shift[0];
    assign serial_last    = serial_valid && w_last;
    assign w_accept       = parallel_valid && parallel_ready;
    assign w_xfer         = serial_valid && serial_ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_xfer) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    r_shift <= parallel_data;
                    r_state <= SHIFT;
                end
            end else if (w_xfer && w_last) begin
                // buffer is never full while accepting, so these cases are exclusive
                if (r_buf_full) begin
                    r_shift    <= r_buf;
                    r_buf_full <= 1'b0;
                end else if (w_accept) begin
                    r_shift <= parallel_data;
                end else begin
                    r_shift <= '0;
                    r_state <= IDLE;
                end
            end else begin
                if (w_xfer) r_shift <= {1'b0, r_shift[width-1:1]};
                if (w_accept) begin
                    r_buf      <= parallel_data;
                    r_buf_full <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the number of bits per parallel word (width >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port parallel_valid, input, 1 bit: the upstream word is valid.
REQ-005 The block SHALL have port parallel_data, input, width bits: the upstream word.
REQ-006 The block SHALL have port parallel_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 The block SHALL have port serial_ready, input, 1 bit: the downstream accepts a bit this cycle (tie high for a consumer without backpressure).
REQ-008 The block SHALL have port serial_valid, output, 1 bit: serial_data is valid.
REQ-009 The block SHALL have port serial_data, output, 1 bit: the current serial bit.
REQ-010 The block SHALL have port serial_last, output, 1 bit: the current bit is bit width-1 of its word.

Function
REQ-011 A word SHALL be accepted on a rising edge where parallel_valid and parallel_ready are both high; a bit SHALL be transferred on a rising edge where serial_valid and serial_ready are both high.
REQ-012 Bits SHALL be emitted LSB first (bit 0 first, bit width-1 last), so a shift-in-from-MSB deserializer downstream reassembles the original word.
REQ-013 Storage SHALL consist of one shift register with occupancy flag (states IDLE = empty, SHIFT = holding a word) and one width-bit holding buffer with a full flag.
REQ-014 A bit counter of $clog2(width) bits SHALL count transferred bits of the current word: 0 on load, +1 per transfer, cleared to 0 after bit width-1.
REQ-015 parallel_ready SHALL equal NOT(holding buffer full), combinationally from registered state only, with no dependence on parallel_valid.
REQ-016 serial_valid SHALL be high exactly when the state is SHIFT; serial_data SHALL be shift register bit 0; serial_last SHALL be high when serial_valid is high and counter == width-1.
REQ-017 IDLE -> SHIFT: an accepted word SHALL load directly into the shift register if the state is IDLE and the buffer is empty; serial_valid SHALL rise the cycle after acceptance with bit 0 (one-cycle latency).
REQ-018 In SHIFT, a transfer that is not the last bit SHALL shift the register right by one and keep the state.
REQ-019 On a transfer of the last bit, if the buffer is full, the buffer word SHALL move to the shift register, the buffer SHALL become empty, and the state SHALL stay SHIFT, with no idle cycle between words.
REQ-020 On a transfer of the last bit with the buffer empty and a simultaneous acceptance, the accepted word SHALL load directly into the shift register and the state SHALL stay SHIFT (gapless).
REQ-021 On a transfer of the last bit with the buffer empty and no acceptance, the state SHALL become IDLE.
REQ-022 Any other acceptance while in SHIFT SHALL write the holding buffer and set it full.
REQ-023 While serial_ready is low, serial_valid, serial_data, serial_last and the counter SHALL hold unchanged.
REQ-024 A word SHALL never be dropped, duplicated or reordered; with serial_ready held high and parallel_valid held high, the throughput SHALL be one word per width cycles.

Reset
REQ-025 While rst is low, regardless of clk, the state SHALL be IDLE, the buffer empty, the counter 0 and the shift register 0; outputs SHALL be serial_valid=0, serial_data=0, serial_last=0, parallel_ready=1.
REQ-026 Reset asserted mid-word SHALL discard the partial word and any buffered word; after reset deasserts, the first output bit SHALL be bit 0 of the next accepted word.

Verification
REQ-027 Single word: width=8, one accept of 8'hA5, serial_ready=1 -> serial_valid high for exactly 8 cycles starting the cycle after accept, bits 1,0,1,0,0,1,0,1, serial_last on the 8th bit only.
REQ-028 Back-to-back: 8'h01, 8'hFF, 8'h80 offered continuously -> 24 consecutive valid cycles with no gap, and parallel_ready low while the buffer is full.
REQ-029 Backpressure: serial_ready toggles 1,0,0,1,... during 8'h3C -> each bit holds while ready is low, the bit sequence still equals 0,0,1,1,1,1,0,0, and no bit is lost.
REQ-030 Boundary: a new word is offered in exactly the last-bit cycle with the buffer empty -> it is accepted and its bit 0 follows the previous bit width-1 in the next cycle.
REQ-031 Reset mid-word: rst pulsed low after 3 bits of 8'hF0, then 8'h0F sent -> outputs are 0 and parallel_ready=1 during reset, then exactly 8 bits 1,1,1,1,0,0,0,0 are emitted.
REQ-032 End-to-end: the output drives serial_to_parallel (width=8) with 100 random words and random serial_ready -> the reassembled words match the inputs in order.
